// File: rtl/line_cmd_sequencer.sv
// Line-drawer register master: queues line commands and replays each one as a
// MODE/BEAM/coordinate/GO register write sequence followed by BUSY polling.
module line_cmd_sequencer #(
  parameter int DEPTH       = 8,
  parameter bit SYNC_VBLANK = 1'b1,
  parameter int POLL_LIMIT  = 4096
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [35:0] cmd_data,
  input  logic [1:0]  mode_cfg,
  input  logic        irq,
  output logic [2:0]  address,
  output logic [7:0]  write_data,
  output logic        write,
  input  logic [7:0]  read_data,
  output logic        active,
  output logic [15:0] lines_done,
  output logic        timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE       = (AW + 1)'(1);

  typedef enum logic [3:0] {
    IDLE, WAIT_VB, WR_MODE, WR_BEAM, WR_STAX, WR_STAY,
    WR_ENDX, WR_ENDY, WR_GO, POLL, POP
  } state_t;

  state_t        state, entry_state;
  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, next_rd;
  logic [AW:0]   count;
  logic          push, pop, irq_q, irq_rise;
  logic [1:0]    step;
  logic [PW-1:0] poll_cnt;
  logic [3:0]    last_beam;
  logic          beam_valid, beam_skip, more_after_pop;
  logic [35:0]   head, line_word;
  logic [2:0]    entry_addr;
  logic [7:0]    entry_data;
  logic          unused_bits;

  assign cmd_ready = count < FULL;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == POP);
  assign irq_rise  = irq && !irq_q;
  assign active    = (state != IDLE);
  assign head      = mem[rd_ptr];
  assign next_rd   = rd_ptr + AW'(1);

  // While popping, the next line is the entry behind the head, or a word being
  // pushed this very cycle into a FIFO that is about to go empty.
  assign more_after_pop = (count > ONE) || push;
  assign line_word = (state == POP) ? ((count > ONE) ? mem[next_rd] : cmd_data) : head;
  assign beam_skip = beam_valid && (line_word[35:32] == last_beam);
  assign unused_bits = ^{read_data[7:1], line_word[23:0]};

  always_comb begin
    entry_state = WR_BEAM;
    entry_addr  = 3'd5;
    entry_data  = {4'b0, line_word[35:32]};
    if (beam_skip) begin
      entry_state = WR_STAX;
      entry_addr  = 3'd0;
      entry_data  = line_word[31:24];
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= next_rd;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      address     <= '0;
      write_data  <= '0;
      write       <= 1'b0;
      step        <= '0;
      poll_cnt    <= '0;
      lines_done  <= '0;
      timeout_err <= 1'b0;
      last_beam   <= '0;
      beam_valid  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_q <= irq;
      write <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            if (SYNC_VBLANK) begin
              state <= WAIT_VB;
            end else begin
              state      <= WR_MODE;
              address    <= 3'd6;
              write_data <= {6'b0, mode_cfg};
              step       <= '0;
            end
          end
        end
        WAIT_VB: begin
          if (irq_rise) begin
            state      <= WR_MODE;
            address    <= 3'd6;
            write_data <= {6'b0, mode_cfg};
            step       <= '0;
          end
        end
        POLL: begin
          if (step != 2'd2) begin
            step <= step + 2'd1;
          end else begin
            step     <= '0;
            poll_cnt <= poll_cnt + PW'(1);
            if (!read_data[0]) begin
              state      <= POP;
              lines_done <= lines_done + 16'd1;
            end else if (poll_cnt == POLL_LAST) begin
              state       <= POP;
              timeout_err <= 1'b1;
            end
          end
        end
        POP: begin
          if (more_after_pop) begin
            state      <= entry_state;
            address    <= entry_addr;
            write_data <= entry_data;
            step       <= '0;
            if (!beam_skip) begin
              last_beam  <= line_word[35:32];
              beam_valid <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          // Every write state: one setup cycle, one strobe cycle, then the next op.
          if (step == 2'd0) begin
            write <= 1'b1;
            step  <= 2'd1;
          end else begin
            step <= '0;
            case (state)
              WR_MODE: begin
                state      <= entry_state;
                address    <= entry_addr;
                write_data <= entry_data;
                if (!beam_skip) begin
                  last_beam  <= line_word[35:32];
                  beam_valid <= 1'b1;
                end
              end
              WR_BEAM: begin
                state      <= WR_STAX;
                address    <= 3'd0;
                write_data <= head[31:24];
              end
              WR_STAX: begin
                state      <= WR_STAY;
                address    <= 3'd1;
                write_data <= head[23:16];
              end
              WR_STAY: begin
                state      <= WR_ENDX;
                address    <= 3'd2;
                write_data <= head[15:8];
              end
              WR_ENDX: begin
                state      <= WR_ENDY;
                address    <= 3'd3;
                write_data <= head[7:0];
              end
              WR_ENDY: begin
                state      <= WR_GO;
                address    <= 3'd4;
                write_data <= 8'h01;
              end
              default: begin
                state    <= POLL;
                address  <= 3'd4;
                poll_cnt <= '0;
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Directed bench for line_cmd_sequencer with a BUSY model that stays high for a
// set number of cycles after each GO write (or forever when stuck).
module tb_line_cmd_sequencer;
  localparam int DEPTH      = 8;
  localparam int POLL_LIMIT = 16;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        irq = 1'b0;
  logic [35:0] cmd_data = '0;
  logic [1:0]  mode_cfg = '0;
  logic [7:0]  read_data;
  logic        cmd_ready, write, active, timeout_err;
  logic [2:0]  address;
  logic [7:0]  write_data;
  logic [15:0] lines_done;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t         wlog[$];
  int          cyc = 0;
  int          busy_cnt = 0;
  int          busy_len = 8;
  int          double_writes = 0;
  int          ld_cyc = 0;
  int          te_cyc = 0;
  bit          busy_stuck = 1'b0;
  logic        prev_write = 1'b0;
  logic        prev_te = 1'b0;
  logic [15:0] prev_ld = '0;

  always #5 pclk = ~pclk;

  line_cmd_sequencer #(
    .DEPTH(DEPTH), .SYNC_VBLANK(1'b1), .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .pclk(pclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .mode_cfg(mode_cfg), .irq(irq), .address(address),
    .write_data(write_data), .write(write), .read_data(read_data),
    .active(active), .lines_done(lines_done), .timeout_err(timeout_err)
  );

  assign read_data = {7'b0, busy_stuck || (busy_cnt != 0)};

  // Bus monitor and BUSY model, sampled mid-cycle.
  always @(negedge pclk) begin
    cyc++;
    if (rst === 1'b1) busy_cnt = 0;
    else if (busy_cnt > 0) busy_cnt--;
    if (write === 1'b1 && rst !== 1'b1) begin
      wlog.push_back('{address, write_data, cyc});
      if (address == 3'd4) busy_cnt = busy_len;
      if (prev_write === 1'b1) double_writes++;
    end
    if (lines_done !== prev_ld) ld_cyc = cyc;
    if (timeout_err === 1'b1 && prev_te !== 1'b1) te_cyc = cyc;
    prev_write = write;
    prev_ld    = lines_done;
    prev_te    = timeout_err;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1; cmd_valid = 1'b0; irq = 1'b0; busy_stuck = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic push_cmd(input logic [35:0] d);
    int t = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_data = d;
    while (cmd_ready !== 1'b1 && t < 100) begin @(negedge pclk); t++; end
    if (cmd_ready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL push_accept: cmd_ready=%b, required 1", cmd_ready);
    end
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_data = '0;
  endtask

  task automatic pulse_irq();
    @(negedge pclk); irq = 1'b1;
    repeat (2) @(negedge pclk);
    irq = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int t = 0;
    @(negedge pclk);
    while (active !== 1'b0 && t < max_cyc) begin @(negedge pclk); t++; end
    if (active !== 1'b0) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL %s_idle: active=%b after %0d cycles, required 0", name, active, t);
    end
  endtask

  task automatic test_reset();
    int b;
    do_reset();
    tests_run++;
    if (address !== 3'd0 || write_data !== 8'd0 || write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: addr=%h data=%h write=%b, required 0/00/0", address, write_data, write);
    end
    tests_run++;
    if (active !== 1'b0 || lines_done !== 16'd0 || timeout_err !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: active=%b lines=%h tmo=%b ready=%b, required 0/0000/0/1",
               active, lines_done, timeout_err, cmd_ready);
    end
    b = wlog.size();
    repeat (5) pulse_irq();
    repeat (5) @(negedge pclk);
    tests_run++;
    if (wlog.size() - b != 0 || active !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle_irq: writes=%0d active=%b, required 0/0", wlog.size() - b, active);
    end
  endtask

  task automatic test_single_line();
    int b;
    logic [2:0] ea [7] = '{3'd6, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] ed [7] = '{8'h03, 8'h0F, 8'h80, 8'h7E, 8'h80, 8'h64, 8'h01};
    do_reset();
    mode_cfg = 2'd3; busy_len = 8;
    b = wlog.size();
    push_cmd({4'hF, 8'd128, 8'd126, 8'd128, 8'd100});
    repeat (20) @(negedge pclk);
    tests_run++;
    if (wlog.size() - b != 0 || active !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_wait_vb: writes=%0d active=%b, required 0/1", wlog.size() - b, active);
    end
    pulse_irq();
    wait_idle(200, "single");
    tests_run++;
    if (wlog.size() - b != 7) begin
      tests_failed++;
      $display("[TB] FAIL single_count: writes=%0d, required 7", wlog.size() - b);
    end
    for (int i = 0; i < 7; i++) begin
      logic [2:0] ga;
      logic [7:0] gd;
      ga = 'x; gd = 'x;
      if (b + i < wlog.size()) begin ga = wlog[b+i].addr; gd = wlog[b+i].data; end
      tests_run++;
      if (ga !== ea[i] || gd !== ed[i]) begin
        tests_failed++;
        $display("[TB] FAIL single_write%0d: got (%h,%h), required (%h,%h)", i, ga, gd, ea[i], ed[i]);
      end
    end
    tests_run++;
    if (lines_done !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL single_lines_done: got %0d, required 1", lines_done);
    end
    if (wlog.size() - b == 7) begin
      tests_run++;
      if (wlog[b+6].cyc - wlog[b].cyc != 12) begin
        tests_failed++;
        $display("[TB] FAIL single_spacing: MODE->GO %0d cycles, required 12", wlog[b+6].cyc - wlog[b].cyc);
      end
      tests_run++;
      if (ld_cyc - wlog[b+6].cyc != 10) begin
        tests_failed++;
        $display("[TB] FAIL single_polls: GO->done %0d cycles, required 10 (three reads)", ld_cyc - wlog[b+6].cyc);
      end
    end
  endtask

  task automatic test_beam_suppress();
    int b;
    logic [2:0] ea [18] = '{3'd6, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                            3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                            3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] ed [18] = '{8'h01, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h01,
                            8'h20, 8'h21, 8'h22, 8'h23, 8'h01,
                            8'h07, 8'h30, 8'h31, 8'h32, 8'h33, 8'h01};
    do_reset();
    mode_cfg = 2'd1; busy_len = 0;
    b = wlog.size();
    push_cmd({4'hF, 8'h10, 8'h11, 8'h12, 8'h13});
    push_cmd({4'hF, 8'h20, 8'h21, 8'h22, 8'h23});
    push_cmd({4'h7, 8'h30, 8'h31, 8'h32, 8'h33});
    pulse_irq();
    wait_idle(300, "beam");
    tests_run++;
    if (wlog.size() - b != 18) begin
      tests_failed++;
      $display("[TB] FAIL beam_count: writes=%0d, required 18", wlog.size() - b);
    end
    for (int i = 0; i < 18; i++) begin
      logic [2:0] ga;
      logic [7:0] gd;
      ga = 'x; gd = 'x;
      if (b + i < wlog.size()) begin ga = wlog[b+i].addr; gd = wlog[b+i].data; end
      tests_run++;
      if (ga !== ea[i] || gd !== ed[i]) begin
        tests_failed++;
        $display("[TB] FAIL beam_write%0d: got (%h,%h), required (%h,%h)", i, ga, gd, ea[i], ed[i]);
      end
    end
    if (wlog.size() - b == 18) begin
      tests_run++;
      if (wlog[b+11].cyc - wlog[b+6].cyc != 14) begin
        tests_failed++;
        $display("[TB] FAIL beam_min_line: GO->GO %0d cycles, required 14", wlog[b+11].cyc - wlog[b+6].cyc);
      end
      tests_run++;
      if (wlog[b+17].cyc - wlog[b+11].cyc != 16) begin
        tests_failed++;
        $display("[TB] FAIL beam_new_beam_line: GO->GO %0d cycles, required 16", wlog[b+17].cyc - wlog[b+11].cyc);
      end
    end
    tests_run++;
    if (lines_done !== 16'd3) begin
      tests_failed++;
      $display("[TB] FAIL beam_lines_done: got %0d, required 3", lines_done);
    end
  endtask

  task automatic test_fifo_full();
    int b;
    int accepted = 0;
    int n_go = 0;
    int n_beam = 0;
    int n_stax = 0;
    do_reset();
    mode_cfg = 2'd2; busy_len = 0;
    b = wlog.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      cmd_valid = 1'b1;
      cmd_data  = {4'h3, 8'(8'h40 + accepted), 8'h00, 8'h00, 8'h00};
      if (cmd_ready === 1'b1) accepted++;
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
    tests_run++;
    if (accepted != 8 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_accept: accepted=%0d ready=%b, required 8/0", accepted, cmd_ready);
    end
    pulse_irq();
    wait_idle(600, "full");
    for (int i = b; i < wlog.size(); i++) begin
      if (wlog[i].addr == 3'd4) n_go++;
      if (wlog[i].addr == 3'd5) n_beam++;
      if (wlog[i].addr == 3'd0) begin
        tests_run++;
        if (wlog[i].data !== 8'(8'h40 + n_stax)) begin
          tests_failed++;
          $display("[TB] FAIL full_order%0d: STAX=%h, required %h", n_stax, wlog[i].data, 8'(8'h40 + n_stax));
        end
        n_stax++;
      end
    end
    tests_run++;
    if (n_stax != 8 || n_go != 8 || n_beam != 1) begin
      tests_failed++;
      $display("[TB] FAIL full_counts: stax=%0d go=%0d beam=%0d, required 8/8/1", n_stax, n_go, n_beam);
    end
    tests_run++;
    if (lines_done !== 16'd8 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_done: lines=%0d ready=%b, required 8/1", lines_done, cmd_ready);
    end
  endtask

  task automatic test_timeout();
    int b;
    int t = 0;
    int go_idx[$];
    do_reset();
    mode_cfg = 2'd0; busy_len = 8; busy_stuck = 1'b1;
    b = wlog.size();
    push_cmd({4'h1, 8'h01, 8'h02, 8'h03, 8'h04});
    push_cmd({4'h2, 8'h05, 8'h06, 8'h07, 8'h08});
    pulse_irq();
    while (timeout_err !== 1'b1 && t < 300) begin @(negedge pclk); t++; end
    busy_stuck = 1'b0;
    tests_run++;
    if (timeout_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_flag: timeout_err=%b after %0d cycles, required 1", timeout_err, t);
    end
    wait_idle(200, "timeout");
    for (int i = b; i < wlog.size(); i++) if (wlog[i].addr == 3'd4) go_idx.push_back(i);
    tests_run++;
    if (go_idx.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL timeout_go_count: got %0d, required 2", go_idx.size());
    end
    if (go_idx.size() > 0) begin
      tests_run++;
      if (te_cyc - wlog[go_idx[0]].cyc != 49) begin
        tests_failed++;
        $display("[TB] FAIL timeout_reads: GO->timeout %0d cycles, required 49 (16 reads)", te_cyc - wlog[go_idx[0]].cyc);
      end
    end
    tests_run++;
    if (lines_done !== 16'd1 || timeout_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_after: lines=%0d tmo=%b, required 1/1", lines_done, timeout_err);
    end
  endtask

  task automatic test_reset_mid_line();
    int b;
    int t = 0;
    do_reset();
    mode_cfg = 2'd2; busy_len = 8;
    push_cmd({4'h5, 8'h11, 8'h22, 8'h33, 8'h44});
    push_cmd({4'h5, 8'h55, 8'h66, 8'h77, 8'h88});
    pulse_irq();
    while (!(address === 3'd2 && write === 1'b0) && t < 100) begin @(negedge pclk); t++; end
    rst = 1'b1;
    @(negedge pclk);
    tests_run++;
    if (write !== 1'b0 || active !== 1'b0 || lines_done !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_abort: write=%b active=%b lines=%0d, required 0/0/0", write, active, lines_done);
    end
    rst = 1'b0;
    b = wlog.size();
    pulse_irq();
    repeat (20) @(negedge pclk);
    tests_run++;
    if (wlog.size() - b != 0 || active !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_fifo_empty: writes=%0d active=%b, required 0/0", wlog.size() - b, active);
    end
    push_cmd({4'h5, 8'h99, 8'hAA, 8'hBB, 8'hCC});
    pulse_irq();
    wait_idle(200, "midreset");
    tests_run++;
    if (wlog.size() - b != 7) begin
      tests_failed++;
      $display("[TB] FAIL midreset_count: writes=%0d, required 7", wlog.size() - b);
    end else begin
      tests_run++;
      if (wlog[b].addr !== 3'd6 || wlog[b].data !== 8'h02 || wlog[b+1].addr !== 3'd5 || wlog[b+1].data !== 8'h05) begin
        tests_failed++;
        $display("[TB] FAIL midreset_rewrite: got (%h,%h),(%h,%h), required (6,02),(5,05)",
                 wlog[b].addr, wlog[b].data, wlog[b+1].addr, wlog[b+1].data);
      end
      tests_run++;
      if (wlog[b+2].data !== 8'h99) begin
        tests_failed++;
        $display("[TB] FAIL midreset_stax: got %h, required 99", wlog[b+2].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_beam_suppress();
    test_fifo_full();
    test_timeout();
    test_reset_mid_line();
    tests_run++;
    if (double_writes != 0) begin
      tests_failed++;
      $display("[TB] FAIL write_pulse_width: %0d back-to-back strobes, required 0", double_writes);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/line_cmd_sequencer.md
Name: line_cmd_sequencer

Overview:
Hardware master for the line-drawer register interface (STAX/STAY/ENDX/ENDY/BUSY/BEAM/MODE at addresses 0-6). It buffers line commands in a small FIFO, waits for the vertical-blank interrupt, programs the draw mode, and then issues each line as a sequence of register writes. After each GO write it polls BUSY until the line completes. It replaces software/bench-driven register sequencing and sits between a command source and the vga_example register port, in the pclk domain.

Parameters:
DEPTH, 8, command FIFO entries (power of 2, >=2)
SYNC_VBLANK, 1, 1 = each batch waits for a rising edge on irq; 0 = start immediately
POLL_LIMIT, 4096, maximum BUSY reads per line before timeout

Ports:
pclk  in  1  pixel clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; high when count < DEPTH
cmd_data  in  36  {beam[3:0], stax[7:0], stay[7:0], endx[7:0], endy[7:0]}
mode_cfg  in  2  MODE value written at batch start (0 HLD, 1 CLR, 2 LIN, 3 EXP)
irq  in  1  vertical-blank interrupt from the drawer
address  out  3  register address
write_data  out  8  register write data
write  out  1  register write strobe
read_data  in  8  register read data
active  out  1  high whenever state != IDLE
lines_done  out  16  count of completed lines, wraps at 0xFFFF->0
timeout_err  out  1  sticky; set on poll timeout, cleared only by rst

Behaviour:
- Reset values: address=0, write_data=0, write=0, active=0, lines_done=0, timeout_err=0, cmd_ready=1 after reset. FIFO is emptied, the beam_valid flag is cleared, and the FSM goes to IDLE. A reset mid-sequence aborts the sequence immediately; a partially written line is not resumed.
- FIFO: a push occurs when cmd_valid && cmd_ready. Pop is internal. When the FIFO is full, a push is refused even if a pop happens in the same cycle. Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- irq edge detect: irq_q is registered. A rise is irq && !irq_q.
- Register write op (2 cycles):
  - W1: drive address and write_data, write=0.
  - W2: hold the same values, write=1.
  - Next op starts the following cycle. write is never high for more than one consecutive cycle.
- Register read op (3 cycles):
  - R1: address=4, write=0.
  - R2: hold.
  - R3: sample read_data.
- FSM states: IDLE, WAIT_VB, WR_MODE, WR_BEAM, WR_STAX, WR_STAY, WR_ENDX, WR_ENDY, WR_GO, POLL, POP.
  - IDLE: FIFO non-empty -> WAIT_VB if SYNC_VBLANK, else WR_MODE.
  - WAIT_VB: an irq rise -> WR_MODE. A rise already in progress at entry does not count (edge only).
  - WR_MODE: writes address 6 with {6'b0, mode_cfg}, sampled at entry -> WR_BEAM.
  - WR_BEAM: if beam_valid and head.beam equals last_beam, skip with zero cycles -> WR_STAX. Otherwise write address 5 with {4'b0, beam}, set last_beam and beam_valid.
  - WR_STAX..WR_ENDY: write addresses 0..3 with the head fields, in order.
  - WR_GO: writes address 4 with 8'h01 -> POLL.
  - POLL: repeated read ops of address 4.
    - Sampled bit0==0 -> POP and increment lines_done.
    - Bit0==1 -> read again.
    - After POLL_LIMIT reads with bit0 still 1: set timeout_err -> POP without incrementing.
  - POP: dequeue one cycle. FIFO non-empty -> WR_BEAM (same batch, no MODE rewrite, no vblank wait). Empty -> IDLE.
- Minimum line cost, beam unchanged, one poll: 10 write cycles + 3 read cycles + 1 POP = 14 cycles.
- cmd_data is captured at push time. Later changes to inputs do not affect queued commands.
- Between ops, address/write_data hold their last values and write=0.

Test Plan:
- Reset/idle: assert rst for 2 cycles -> all outputs at reset values. No write pulse while the FIFO is empty and irq is toggling.
- Single line with SYNC_VBLANK=1: push {F,128,126,128,100}, mode_cfg=3, no irq -> no writes. On irq rise, writes are (6,03),(5,0F),(0,80),(1,7E),(2,80),(3,64),(4,01). Model returns BUSY=1 twice then 0 -> three polls, lines_done=1, active falls.
- Beam suppression: push three lines with beams F,F,7 back to back -> BEAM writes occur only before line 1 (0F) and line 3 (07). MODE is written once per batch.
- FIFO full: with DEPTH=8, hold the model busy and push 10 commands -> cmd_ready drops after 8 accepted (9 if the first has popped). Every accepted command is drawn in order; none is lost or duplicated.
- Timeout: BUSY stuck at 1 with POLL_LIMIT=16 -> exactly 16 reads, timeout_err=1, lines_done unchanged, next queued line proceeds.
- Reset mid-line: assert rst during WR_ENDX -> the next cycle shows write=0 and the FIFO empty. A new push after reset starts a fresh batch with MODE rewritten and beam rewritten.
